uninasoc_irq_ctrl: RTL and testbench



---
 rtl/uninasoc_irq_ctrl.sv | 148 ++++++++++++++
 tb/tb_uninasoc_irq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uninasoc_irq_ctrl.sv
// AXI4-Lite interrupt controller: edge-detects NUM_IRQ sources, tracks pending/enable/in-service
// state and raises a single registered request; software claims (lowest index first) and completes.
module uninasoc_irq_ctrl #(
  parameter int NUM_IRQ    = 3,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [NUM_IRQ-1:0]    irq_src_i,
  output logic                  irq_o,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam logic W_IDLE = 1'b0;
  localparam logic W_RESP = 1'b1;
  localparam logic R_IDLE = 1'b0;
  localparam logic R_DATA = 1'b1;

  localparam logic [9:0] REG_PENDING = 10'h000;
  localparam logic [9:0] REG_ENABLE  = 10'h001;
  localparam logic [9:0] REG_CLAIM   = 10'h002;

  logic [NUM_IRQ-1:0] prev_q, pending_q, enable_q, in_service_q;
  logic [NUM_IRQ-1:0] eligible, rising, claim_mask, complete_mask;
  logic               w_state_q, r_state_q;
  logic               wr_fire, rd_fire;
  logic [9:0]         waddr, raddr;
  logic [4:0]         claim_id;
  logic [31:0]        rdata_q, rdata_next;
  logic [1:0]         rresp_q, rresp_next, bresp_q, bresp_next;
  logic               irq_q;
  logic               unused_bits;

  assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_wstrb};

  assign waddr    = s_axi_awaddr[11:2];
  assign raddr    = s_axi_araddr[11:2];
  assign eligible = pending_q & enable_q & ~in_service_q;
  assign rising   = irq_src_i & ~prev_q;

  // Ready signals are held low while reset is asserted so nothing is accepted during reset.
  assign wr_fire       = (w_state_q == W_IDLE) & s_axi_awvalid & s_axi_wvalid & ~reset_i;
  assign s_axi_awready = wr_fire;
  assign s_axi_wready  = wr_fire;
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bresp   = bresp_q;

  assign s_axi_arready = (r_state_q == R_IDLE) & ~reset_i;
  assign rd_fire       = s_axi_arready & s_axi_arvalid;
  assign s_axi_rvalid  = (r_state_q == R_DATA);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  assign irq_o = irq_q;

  always_comb begin
    claim_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) claim_id = 5'(i + 1);
    end
  end

  always_comb begin
    rdata_next = '0;
    rresp_next = 2'b00;
    case (raddr)
      REG_PENDING: rdata_next = 32'(pending_q);
      REG_ENABLE:  rdata_next = 32'(enable_q);
      REG_CLAIM:   rdata_next = 32'(claim_id);
      default:     rresp_next = 2'b10;
    endcase
  end

  always_comb begin
    bresp_next = 2'b00;
    if (waddr != REG_PENDING && waddr != REG_ENABLE && waddr != REG_CLAIM) bresp_next = 2'b10;
  end

  // Per-source state; OR-ing the set term last makes a new edge beat a claim clear,
  // and a claim beat a same-cycle completion.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
    assign claim_mask[gi]    = rd_fire && (raddr == REG_CLAIM) && (claim_id == 5'(gi + 1));
    assign complete_mask[gi] = wr_fire && (waddr == REG_CLAIM) && (s_axi_wdata[4:0] == 5'(gi + 1));

    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        pending_q[gi]    <= 1'b0;
        in_service_q[gi] <= 1'b0;
      end else begin
        pending_q[gi]    <= (pending_q[gi] & ~claim_mask[gi]) | rising[gi];
        in_service_q[gi] <= (in_service_q[gi] & ~complete_mask[gi]) | claim_mask[gi];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      prev_q    <= '0;
      enable_q  <= '0;
      irq_q     <= 1'b0;
      w_state_q <= W_IDLE;
      bresp_q   <= 2'b00;
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      prev_q <= irq_src_i;
      irq_q  <= |eligible;

      if (w_state_q == W_IDLE) begin
        if (wr_fire) begin
          bresp_q   <= bresp_next;
          w_state_q <= W_RESP;
          if (waddr == REG_ENABLE && s_axi_wstrb[0]) enable_q <= s_axi_wdata[NUM_IRQ-1:0];
        end
      end else if (s_axi_bready) begin
        w_state_q <= W_IDLE;
      end

      if (r_state_q == R_IDLE) begin
        if (rd_fire) begin
          rdata_q   <= rdata_next;
          rresp_q   <= rresp_next;
          r_state_q <= R_DATA;
        end
      end else if (s_axi_rready) begin
        r_state_q <= R_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uninasoc_irq_ctrl.sv
// Directed and randomized checks of uninasoc_irq_ctrl against a transaction-level model of
// the pending/enable/in-service bookkeeping.
module tb_uninasoc_irq_ctrl;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [N-1:0]  irq_src = '0;
  logic          irq_o;
  logic [31:0]   awaddr = '0, araddr = '0, wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;

  int checks = 0;
  int failures = 0;

  // Reference state, kept as plain bit vectors updated by the rules at each clock edge.
  bit [N-1:0] m_pend, m_en, m_insvc, m_prev;
  bit         m_irq;

  always #5 clk = ~clk;

  uninasoc_irq_ctrl #(.NUM_IRQ(N), .ADDR_WIDTH(32)) dut (
    .clock_i(clk), .reset_i(reset_i), .irq_src_i(irq_src), .irq_o(irq_o),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lowest_id(input bit [N-1:0] v);
    int id = 0;
    for (int i = 0; i < N; i++) if (v[i] && id == 0) id = i + 1;
    return id;
  endfunction

  // One clock edge; rd/wr mean an AR / AW+W handshake happens at this edge.
  task automatic step(input bit rd, input bit wr, output logic [31:0] rexp,
                      output logic [1:0] rre, output logic [1:0] bre);
    bit [N-1:0] elig, rise, clr, set, cclr, new_en;
    int id, cid;
    elig = m_pend & m_en & ~m_insvc;
    rise = irq_src & ~m_prev;
    clr = '0; set = '0; cclr = '0; new_en = m_en;
    rexp = '0; rre = 2'b00; bre = 2'b00;
    if (rd) begin
      case (araddr[11:2])
        10'd0: rexp = 32'(m_pend);
        10'd1: rexp = 32'(m_en);
        10'd2: begin
          id = lowest_id(elig);
          rexp = 32'(id);
          if (id != 0) begin clr[id-1] = 1'b1; set[id-1] = 1'b1; end
        end
        default: rre = 2'b10;
      endcase
    end
    if (wr) begin
      case (awaddr[11:2])
        10'd0: ;
        10'd1: if (wstrb[0]) new_en = wdata[N-1:0];
        10'd2: begin
          cid = int'(wdata[4:0]);
          if (cid >= 1 && cid <= N) cclr[cid-1] = 1'b1;
        end
        default: bre = 2'b10;
      endcase
    end
    @(posedge clk);
    m_irq   = |elig;
    m_prev  = irq_src;
    m_pend  = (m_pend & ~clr) | rise;
    m_insvc = (m_insvc & ~cclr) | set;
    m_en    = new_en;
    #1;
    chk("irq_o", {31'd0, irq_o}, {31'd0, m_irq});
  endtask

  task automatic idle(input int n);
    logic [31:0] d; logic [1:0] a, b;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, d, a, b);
  endtask

  // Full read and/or write transaction with response ready held low for 'hold' cycles.
  task automatic xact(input bit rd, input logic [11:0] ra, input bit wr, input logic [11:0] wa,
                      input logic [31:0] wd, input logic [3:0] ws, input int hold,
                      output logic [31:0] rd_got);
    logic [31:0] rexp, d; logic [1:0] rre, bre, a, b;
    araddr = 32'(ra); arvalid = rd;
    awaddr = 32'(wa); wdata = wd; wstrb = ws; awvalid = wr; wvalid = wr;
    #1;
    if (rd) chk("arready", {31'd0, arready}, 32'd1);
    if (wr) chk("awready_wready", {30'd0, awready, wready}, 32'd3);
    step(rd, wr, rexp, rre, bre);
    arvalid = 0; awvalid = 0; wvalid = 0;
    rd_got = rdata;
    for (int i = 0; i <= hold; i++) begin
      if (rd) begin
        chk("rvalid", {31'd0, rvalid}, 32'd1);
        chk("rdata", rdata, rexp);
        chk("rresp", {30'd0, rresp}, {30'd0, rre});
      end
      if (wr) begin
        chk("bvalid", {31'd0, bvalid}, 32'd1);
        chk("bresp", {30'd0, bresp}, {30'd0, bre});
      end
      if (i == hold) begin rready = rd; bready = wr; end
      step(1'b0, 1'b0, d, a, b);
    end
    rready = 0; bready = 0;
    chk("resp_closed", {30'd0, rvalid, bvalid}, 32'd0);
  endtask

  task automatic do_reset();
    reset_i = 1; arvalid = 0; awvalid = 0; wvalid = 0; rready = 0; bready = 0; irq_src = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {23'd0, irq_o, awready, wready, bvalid, arready, rvalid, bresp, rresp}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    m_pend = '0; m_en = '0; m_insvc = '0; m_prev = '0; m_irq = 0;
    reset_i = 0;
    #1;
    chk("arready_after_rst", {31'd0, arready}, 32'd1);
  endtask

  function automatic logic [11:0] addr_of(input int k);
    case (k)
      0: return 12'h000;
      1: return 12'h004;
      2: return 12'h008;
      default: return 12'h00C;
    endcase
  endfunction

  logic [31:0] got, d;
  logic [1:0]  ra, rb;

  initial begin
    // Reset and empty PENDING.
    do_reset();
    xact(1, 12'h000, 0, 12'h0, 0, 0, 0, got);
    chk("pending_after_reset", got, 32'h0);

    // Pending is captured while disabled; enabling raises irq two edges after the write.
    irq_src = 3'b010; idle(1); irq_src = 3'b000; idle(2);
    chk("irq_disabled", {31'd0, irq_o}, 32'd0);
    xact(1, 12'h000, 0, 12'h0, 0, 0, 0, got);
    chk("pending_src1", got, 32'h2);
    xact(0, 12'h0, 1, 12'h004, 32'h7, 4'hF, 0, got);
    chk("irq_after_enable", {31'd0, irq_o}, 32'd1);

    // Priority claim order 1, 3, 0.
    do_reset();
    xact(0, 12'h0, 1, 12'h004, 32'h7, 4'h1, 0, got);
    irq_src = 3'b101; idle(1); irq_src = 3'b000; idle(2);
    xact(1, 12'h008, 0, 12'h0, 0, 0, 0, got); chk("claim_first", got, 32'd1);
    xact(1, 12'h008, 0, 12'h0, 0, 0, 0, got); chk("claim_second", got, 32'd3);
    chk("irq_low_after_claims", {31'd0, irq_o}, 32'd0);
    xact(1, 12'h008, 0, 12'h0, 0, 0, 0, got); chk("claim_empty", got, 32'd0);
    xact(1, 12'h000, 0, 12'h0, 0, 0, 0, got); chk("pending_cleared", got, 32'd0);

    // In-service masking until COMPLETE.
    do_reset();
    xact(0, 12'h0, 1, 12'h004, 32'h1, 4'h1, 0, got);
    irq_src = 3'b001; idle(1); irq_src = 3'b000; idle(2);
    xact(1, 12'h008, 0, 12'h0, 0, 0, 0, got); chk("claim_id1", got, 32'd1);
    irq_src = 3'b001; idle(1); irq_src = 3'b000; idle(3);
    chk("irq_masked_in_service", {31'd0, irq_o}, 32'd0);
    xact(0, 12'h0, 1, 12'h008, 32'h1, 4'hF, 0, got);
    chk("irq_after_complete", {31'd0, irq_o}, 32'd1);
    xact(1, 12'h008, 0, 12'h0, 0, 0, 0, got); chk("reclaim_id1", got, 32'd1);

    // A new edge in the claim cycle keeps the pending bit set.
    do_reset();
    xact(0, 12'h0, 1, 12'h004, 32'h4, 4'h1, 0, got);
    irq_src = 3'b100; idle(1); irq_src = 3'b000; idle(2);
    irq_src = 3'b100;
    xact(1, 12'h008, 0, 12'h0, 0, 0, 0, got); chk("claim_race_id", got, 32'd3);
    irq_src = 3'b000;
    xact(1, 12'h000, 0, 12'h0, 0, 0, 0, got); chk("pending_after_race", got, 32'h4);

    // Unmapped offset with stalled responses; ENABLE ignores writes without wstrb[0].
    xact(1, 12'h00C, 1, 12'h00C, 32'hFFFF_FFFF, 4'hF, 5, got);
    chk("bad_offset_rdata", got, 32'd0);
    xact(0, 12'h0, 1, 12'h004, 32'h0, 4'hE, 0, got);
    xact(1, 12'h004, 0, 12'h0, 0, 0, 0, got); chk("enable_wstrb_gate", got, 32'h4);

    // Reset during outstanding responses drops them.
    araddr = 0; arvalid = 1; awaddr = 32'h4; wdata = 32'h7; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    step(1, 1, d, ra, rb);
    arvalid = 0; awvalid = 0; wvalid = 0;
    chk("resp_pending_before_rst", {30'd0, rvalid, bvalid}, 32'd3);
    do_reset();
    xact(1, 12'h004, 0, 12'h0, 0, 0, 0, got); chk("enable_after_midrst", got, 32'd0);

    // Randomized traffic against the model.
    for (int it = 0; it < 300; it++) begin
      irq_src = N'($urandom_range(0, (1 << N) - 1));
      idle($urandom_range(0, 2));
      xact($urandom_range(0, 1), addr_of($urandom_range(0, 3)),
           $urandom_range(0, 1), addr_of($urandom_range(0, 3)),
           {$urandom_range(0, 255), 24'd0} | 32'($urandom_range(0, 7)),
           4'($urandom_range(0, 15)), $urandom_range(0, 2), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
